prbs31_checker: RTL and testbench
=================================

# prbs31_checker

Receive-side companion to the team's PRBS31 generator (polynomial x^31 + x^28 + 1, serial output = MSB of the LFSR). Accepts a serial bit stream with a qualifier, self-synchronises to the PRBS31 sequence, declares lock, then counts bit errors and total checked bits for BER measurement. Sits between a deserialiser or loopback pin and the status readout of a test-chip top level.

## Interface
Parameters:
- LOCK_MATCHES, 64: consecutive correct predictions required to declare lock.
- LOSS_WINDOW, 256: length, in checked bits, of the loss-of-lock observation window.
- LOSS_ERRORS, 8: errors within one window that force loss of lock.
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset, sampled on clk).
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is consumed on this cycle; when 0 all state holds.
- clear  in  1  synchronous clear of err_count and bit_count; state and lock unaffected.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per detected error while locked.
- err_count  out  CNT_W  saturating error count.
- bit_count  out  32  saturating count of bits checked while locked.

## Operation
- 31-bit history register sr; on each valid bit sr <= {sr[29:0], b}; sr[0] is newest. Prediction p = sr[27] ^ sr[30].
- States: FILL, HUNT, LOCKED. Only valid cycles advance anything.
- FILL: b = bit_in; fill counter counts 31 valid bits, then -> HUNT with match counter 0. No comparisons.
- HUNT: b = bit_in (self-synchronising). Compare bit_in with p. Match and next sr nonzero: match counter +1; on reaching LOCK_MATCHES -> LOCKED. Mismatch, or next sr all-zero: match counter <= 0, stay HUNT. All-zero stream must never lock.
- LOCKED: b = p (free-running reference; one line error yields exactly one counted error, no multiplication). bit_count +1 per valid bit; on bit_in != p: err_pulse, err_count +1, window error counter +1.
- Window: counter over valid bits in LOCKED; at LOSS_WINDOW bits both window counters restart at 0. If window error count reaches LOSS_ERRORS -> FILL (fill counter 0, match counter 0), locked drops. The error that triggers loss is still counted.
- Counters saturate at all-ones; no wrap.
- clear: err_count, bit_count <= 0; clear has priority over a same-cycle increment (result 0).
- rst_n: state FILL, sr 0, all internal counters 0; locked 0, err_pulse 0, err_count 0, bit_count 0. Reset mid-operation behaves identically; relock requires full FILL + HUNT.

## Timing
- All outputs registered. Valid bit sampled at edge t: err_pulse, err_count, bit_count reflect it after edge t+1 (one-cycle latency).
- Clean stream, continuous valid: locked asserts after the edge sampling valid bit number 31 + LOCK_MATCHES (95 by default).
- locked deasserts at the same edge that samples the LOSS_ERRORS-th error of a window.
- err_pulse is high for exactly one cycle per error; never high outside LOCKED.
- bit_valid low cycles insert stalls with no effect on counts, latency in valid bits, or lock state.

## Test plan
- Generator seed 1 feeding bit_in, valid always 1 -> locked rises after bit 95; after 1000 further bits err_count = 0, bit_count = 1000.
- Locked, flip one bit -> single err_pulse one cycle later, err_count = 1, locked stays 1, subsequent bits error-free.
- Locked, flip 8 bits within 100 bits -> locked falls at 8th error, err_count = 8; clean stream resumes -> locked again after 95 more valid bits.
- bit_in held 0 (and separately held 1) for 2000 bits -> locked never asserts, err_count = 0.
- Clean locked stream with bit_valid toggling 1/0 every cycle -> identical lock point in valid-bit index (95) and counts as continuous case.
- clear asserted same cycle as an error -> err_count = 0 next cycle; rst_n pulsed mid-lock -> all outputs 0 next cycle, relock after 95 valid bits.

Source files
------------

// File: rtl/prbs31_checker_if.sv
// Serial stream input and BER status outputs shared by a PRBS31 source/readout and the checker.
interface prbs31_checker_if #(
  parameter int CNT_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [31:0]      bit_count;

  modport master (
    output bit_in, bit_valid, clear,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  bit_in, bit_valid, clear,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-synchronising lock search,
// then free-running comparison with windowed loss-of-lock and saturating BER counters.
module prbs31_checker #(
  parameter int LOCK_MATCHES = 64,
  parameter int LOSS_WINDOW  = 256,
  parameter int LOSS_ERRORS  = 8,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst_n,
  prbs31_checker_if.slave bus
);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = $clog2(LOSS_WINDOW);
  localparam int EW = $clog2(LOSS_ERRORS + 1);

  typedef enum logic [1:0] {S_FILL, S_HUNT, S_LOCKED} state_t;

  state_t           state_q;
  logic [30:0]      sr_q;
  logic [4:0]       fill_q;
  logic [MW-1:0]    match_q;
  logic [WW-1:0]    win_cnt_q;
  logic [EW-1:0]    win_err_q;
  logic             locked_q;
  logic             hit_q;
  logic             miss_q;
  logic             clr_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_count_q;
  logic [31:0]      bit_count_q;

  logic             pred;
  logic             mismatch;
  logic [30:0]      sr_rx_d;
  logic [EW-1:0]    win_err_d;

  assign pred      = sr_q[27] ^ sr_q[30];
  assign mismatch  = bus.bit_in ^ pred;
  assign sr_rx_d   = {sr_q[29:0], bus.bit_in};
  assign win_err_d = win_err_q + EW'(mismatch);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_FILL;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      clr_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      clr_q  <= bus.clear;
      if (bus.bit_valid) begin
        unique case (state_q)
          S_FILL: begin
            sr_q <= sr_rx_d;
            if (fill_q == 5'd30) begin
              fill_q  <= '0;
              match_q <= '0;
              state_q <= S_HUNT;
            end else begin
              fill_q <= fill_q + 5'd1;
            end
          end
          S_HUNT: begin
            sr_q <= sr_rx_d;
            // An all-zero history trivially predicts zeros, so it must never build lock.
            if (mismatch || (sr_rx_d == '0)) begin
              match_q <= '0;
            end else if (match_q == MW'(LOCK_MATCHES - 1)) begin
              match_q   <= '0;
              win_cnt_q <= '0;
              win_err_q <= '0;
              locked_q  <= 1'b1;
              state_q   <= S_LOCKED;
            end else begin
              match_q <= match_q + MW'(1);
            end
          end
          S_LOCKED: begin
            // Feed back the prediction so a line error is counted once, not three times.
            sr_q   <= {sr_q[29:0], pred};
            hit_q  <= 1'b1;
            miss_q <= mismatch;
            if (win_err_d == EW'(LOSS_ERRORS)) begin
              fill_q    <= '0;
              match_q   <= '0;
              win_cnt_q <= '0;
              win_err_q <= '0;
              locked_q  <= 1'b0;
              state_q   <= S_FILL;
            end else if (win_cnt_q == WW'(LOSS_WINDOW - 1)) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + WW'(1);
              win_err_q <= win_err_d;
            end
          end
          default: begin
            locked_q <= 1'b0;
            state_q  <= S_FILL;
          end
        endcase
      end

      err_pulse_q <= miss_q;
      // A clear also discards the bit sampled alongside it, whose increment lands one edge later.
      if (bus.clear) begin
        err_count_q <= '0;
        bit_count_q <= '0;
      end else if (!clr_q) begin
        if (hit_q && (bit_count_q != '1)) bit_count_q <= bit_count_q + 32'd1;
        if (miss_q && (err_count_q != '1)) err_count_q <= err_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;
endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: table of stream scenarios plus clear and mid-lock reset sequences,
// with an err_pulse scoreboard fed as flipped bits are driven.
`timescale 1ns/1ps
module tb_prbs31_checker;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  prbs31_checker_if #(.CNT_W(CNT_W)) bus ();

  prbs31_checker #(
    .LOCK_MATCHES(64),
    .LOSS_WINDOW (256),
    .LOSS_ERRORS (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int mode;        // 0 PRBS seed 1, 1 constant 0, 2 constant 1
    int nbits;
    int flip_at;
    int flip_n;
    int flip_gap;
    bit toggle;
    int exp_rise;
    int exp_fall;
    int exp_relock;
    bit exp_locked;
    int exp_err;
    int exp_bits;
  } row_t;

  row_t        rows[8];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nvalid = 0;
  int          rise_first = -1;
  int          rise_last = -1;
  int          fall_idx = -1;
  logic        prev_locked = 1'b0;
  logic [30:0] gen;
  int          exp_pulse[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic gen_bit(output logic b);
    b   = gen[30];
    gen = {gen[29:0], gen[30] ^ gen[27]};
  endtask

  task automatic clk_step(input logic b, input logic v, input logic clr, input logic r);
    bus.bit_in    = b;
    bus.bit_valid = v;
    bus.clear     = clr;
    rst_n         = r;
    @(posedge clk);
    #1;
    cyc++;
    if (v && !r) nvalid++;
    if (bus.locked && !prev_locked) begin
      if (rise_first < 0) rise_first = nvalid;
      rise_last = nvalid;
    end
    if (!bus.locked && prev_locked) fall_idx = nvalid;
    prev_locked = bus.locked;
    if (bus.err_pulse) begin
      total++;
      if (exp_pulse.size() > 0 && exp_pulse[0] == cyc) begin
        void'(exp_pulse.pop_front());
      end else begin
        bad++;
        $display("FAIL err_pulse: got 1 at cycle %0d required 0", cyc);
      end
    end
    while (exp_pulse.size() > 0 && exp_pulse[0] < cyc) begin
      total++;
      bad++;
      $display("FAIL err_pulse: got 0 at cycle %0d required 1", exp_pulse[0]);
      void'(exp_pulse.pop_front());
    end
  endtask

  task automatic do_reset();
    clk_step(1'b0, 1'b0, 1'b0, 1'b1);
    clk_step(1'b0, 1'b0, 1'b0, 1'b0);
    nvalid      = 0;
    rise_first  = -1;
    rise_last   = -1;
    fall_idx    = -1;
    prev_locked = 1'b0;
    gen         = 31'd1;
  endtask

  // One valid PRBS bit, optionally inverted; an inverted bit while locked expects a pulse.
  task automatic send_prbs(input logic flip, input logic clr, input logic toggle);
    logic b;
    gen_bit(b);
    if (flip) exp_pulse.push_back(cyc + 2);
    clk_step(b ^ flip, 1'b1, clr, 1'b0);
    if (toggle) clk_step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) clk_step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.clear     = 1'b0;
    gen           = 31'd1;

    //            mode nbits  at  n gap tg rise fall relk lk err  bits
    rows[0] = '{0, 1095,   0, 0,  1, 0,  95,  -1,  95, 1, 0, 1000};
    rows[1] = '{0, 1095, 300, 1,  1, 0,  95,  -1,  95, 1, 1, 1000};
    rows[2] = '{0, 1000, 200, 8, 10, 0,  95, 270, 365, 1, 8,  810};
    rows[3] = '{0, 1095, 200, 7, 10, 0,  95,  -1,  95, 1, 7, 1000};
    rows[4] = '{0, 1095, 330, 8,  5, 0,  95,  -1,  95, 1, 8, 1000};
    rows[5] = '{1, 2000,   0, 0,  1, 0,  -1,  -1,  -1, 0, 0,    0};
    rows[6] = '{2, 2000,   0, 0,  1, 0,  -1,  -1,  -1, 0, 0,    0};
    rows[7] = '{0, 1095,   0, 0,  1, 1,  95,  -1,  95, 1, 0, 1000};

    clk_step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_locked", bus.locked, 0);
    check("reset_err_pulse", bus.err_pulse, 0);
    check("reset_err_count", bus.err_count, 0);
    check("reset_bit_count", bus.bit_count, 0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int k = 1; k <= rows[r].nbits; k++) begin
        if (rows[r].mode == 0) begin
          logic flip;
          flip = (rows[r].flip_n > 0) && (k >= rows[r].flip_at) &&
                 ((k - rows[r].flip_at) % rows[r].flip_gap == 0) &&
                 ((k - rows[r].flip_at) / rows[r].flip_gap < rows[r].flip_n);
          send_prbs(flip, 1'b0, rows[r].toggle);
        end else begin
          clk_step(rows[r].mode == 2, 1'b1, 1'b0, 1'b0);
        end
      end
      drain();
      check($sformatf("row%0d_rise", r), rise_first, rows[r].exp_rise);
      check($sformatf("row%0d_fall", r), fall_idx, rows[r].exp_fall);
      check($sformatf("row%0d_relock", r), rise_last, rows[r].exp_relock);
      check($sformatf("row%0d_locked", r), bus.locked, rows[r].exp_locked);
      check($sformatf("row%0d_err_count", r), bus.err_count, rows[r].exp_err);
      check($sformatf("row%0d_bit_count", r), bus.bit_count, rows[r].exp_bits);
      check($sformatf("row%0d_pulses_left", r), exp_pulse.size(), 0);
      exp_pulse.delete();
      $display("row %0d: rise=%0d fall=%0d relock=%0d err=%0d bits=%0d",
               r, rise_first, fall_idx, rise_last, bus.err_count, bus.bit_count);
    end

    // Clear coinciding with an error: neither the pending nor the new error survives.
    do_reset();
    for (int k = 1; k <= 300; k++) send_prbs(k == 250, 1'b0, 1'b0);
    check("clr_pre_err_count", bus.err_count, 1);
    send_prbs(1'b1, 1'b1, 1'b0);
    check("clr_err_count_t", bus.err_count, 0);
    clk_step(1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_err_count_t1", bus.err_count, 0);
    check("clr_bit_count_t1", bus.bit_count, 0);
    for (int k = 0; k < 100; k++) send_prbs(1'b0, 1'b0, 1'b0);
    drain();
    check("clr_post_err_count", bus.err_count, 0);
    check("clr_post_bit_count", bus.bit_count, 100);
    check("clr_post_locked", bus.locked, 1);
    check("clr_pulses_left", exp_pulse.size(), 0);
    $display("clear seq: err=%0d bits=%0d locked=%0d", bus.err_count, bus.bit_count, bus.locked);

    // Reset in the middle of a locked run, stream keeps flowing afterwards.
    do_reset();
    for (int k = 1; k <= 400; k++) send_prbs(k == 350, 1'b0, 1'b0);
    drain();
    check("mid_pre_err_count", bus.err_count, 1);
    check("mid_pre_locked", bus.locked, 1);
    clk_step(1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_locked", bus.locked, 0);
    check("mid_rst_err_pulse", bus.err_pulse, 0);
    check("mid_rst_err_count", bus.err_count, 0);
    check("mid_rst_bit_count", bus.bit_count, 0);
    nvalid      = 0;
    rise_first  = -1;
    prev_locked = 1'b0;
    for (int k = 0; k < 200; k++) send_prbs(1'b0, 1'b0, 1'b0);
    drain();
    check("mid_relock_rise", rise_first, 95);
    check("mid_relock_err_count", bus.err_count, 0);
    check("mid_relock_bit_count", bus.bit_count, 105);
    $display("reset seq: relock=%0d err=%0d bits=%0d", rise_first, bus.err_count, bus.bit_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
